// File: rtl/health_pkg.sv
// Shared types and defaults for the health bar controller: FSM encoding,
// HP width, default HP and bar geometry, and the HP-to-pixel length helper.
package health_pkg;

  localparam int HP_W  = 8;
  localparam int PIX_W = 12;

  typedef logic [HP_W-1:0]  hp_t;
  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    IFRAME = 2'd1,
    DEAD   = 2'd2
  } hb_state_e;

  localparam int HP_MAX_DEF        = 92;
  localparam int DAMAGE_DEF        = 1;
  localparam int IFRAME_FRAMES_DEF = 2;
  localparam int BAR_X_DEF         = 256;
  localparam int BAR_Y_DEF         = 400;
  localparam int BAR_SCALE_DEF     = 1;
  localparam int BAR_H_DEF         = 20;
  localparam int BORDER_DEF        = 2;
  localparam int KR_DIV_DEF        = 30;

  // Pixel length of a bar segment holding `v` HP points.
  function automatic pix_t hp_to_len(input hp_t v, input int scale);
    return pix_t'(v) * pix_t'(scale);
  endfunction

endpackage

// File: rtl/health_bar_controller_if.sv
// Frame/hit/heal inputs, pixel coordinates and health/bar outputs of the
// health bar controller. master = stimulus side, slave = controller side.
interface health_bar_controller_if;
  import health_pkg::*;

  logic       frame_tick;
  logic       is_trigger_player;
  logic       heal_valid;
  hp_t        heal_amount;
  logic [9:0] x;
  logic [9:0] y;
  hp_t        hp;
  logic       dead;
  logic       invulnerable;
  logic       healt_bar_signal;
  logic       healt_bar_border_signal;
  logic       karma_bar_signal;

  modport master (
    output frame_tick, is_trigger_player, heal_valid, heal_amount, x, y,
    input  hp, dead, invulnerable, healt_bar_signal, healt_bar_border_signal,
           karma_bar_signal
  );

  modport slave (
    input  frame_tick, is_trigger_player, heal_valid, heal_amount, x, y,
    output hp, dead, invulnerable, healt_bar_signal, healt_bar_border_signal,
           karma_bar_signal
  );

endinterface

// File: rtl/bar_geometry.sv
// Pure combinational hit-test for a horizontal bar: a solid part
// [0, solid_len), a trailing segment [solid_len, bar_len) and a border ring
// BORDER pixels thick around the BAR_W x BAR_H interior.
module bar_geometry
  import health_pkg::*;
#(
  parameter int BAR_X  = BAR_X_DEF,
  parameter int BAR_Y  = BAR_Y_DEF,
  parameter int BAR_W  = HP_MAX_DEF * BAR_SCALE_DEF,
  parameter int BAR_H  = BAR_H_DEF,
  parameter int BORDER = BORDER_DEF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  pix_t       solid_len,
  input  pix_t       bar_len,
  output logic       solid,
  output logic       seg,
  output logic       border
);

  localparam pix_t X0 = pix_t'(BAR_X);
  localparam pix_t X1 = pix_t'(BAR_X + BAR_W);
  localparam pix_t Y0 = pix_t'(BAR_Y);
  localparam pix_t Y1 = pix_t'(BAR_Y + BAR_H);
  localparam pix_t BD = pix_t'(BORDER);

  // Coordinates widened so the left/top border test never underflows.
  pix_t xe, ye;
  logic in_interior, in_outer;

  assign xe = pix_t'(x);
  assign ye = pix_t'(y);

  assign in_interior = (xe >= X0) && (xe < X1) && (ye >= Y0) && (ye < Y1);
  assign in_outer    = (xe + BD >= X0) && (xe < X1 + BD) &&
                       (ye + BD >= Y0) && (ye < Y1 + BD);

  assign solid  = in_interior && (xe < X0 + solid_len);
  assign seg    = in_interior && (xe >= X0 + solid_len) && (xe < X0 + bar_len);
  assign border = in_outer && !in_interior;

endmodule

// File: rtl/health_bar_controller.sv
// Player HP tracker with per-frame damage, invulnerability frames and heal,
// plus zero-latency health bar pixel generation.
// Optional karma drain is enabled by defining HEALTH_BAR_KARMA_EN.
module health_bar_controller
  import health_pkg::*;
#(
  parameter int HP_MAX        = HP_MAX_DEF,
  parameter int DAMAGE        = DAMAGE_DEF,
  parameter int IFRAME_FRAMES = IFRAME_FRAMES_DEF,
  parameter int BAR_X         = BAR_X_DEF,
  parameter int BAR_Y         = BAR_Y_DEF,
  parameter int BAR_SCALE     = BAR_SCALE_DEF,
  parameter int BAR_H         = BAR_H_DEF,
  parameter int BORDER        = BORDER_DEF,
  parameter int KR_DIV        = KR_DIV_DEF
) (
  input logic                    clk,
  input logic                    reset,
  health_bar_controller_if.slave bus
);

  localparam hp_t HP_MAX_V = hp_t'(HP_MAX);
  localparam hp_t DAMAGE_V = hp_t'(DAMAGE);
  localparam hp_t IFR_V    = hp_t'(IFRAME_FRAMES);
  localparam hp_t ONE      = hp_t'(1);

  hb_state_e   state_q, state_d;
  hp_t         hp_q, hp_d;
  hp_t         iframe_q, iframe_d;
  logic        hit_q, hit_d;
  logic        dead_q, dead_d;
  logic        inv_q, inv_d;
  logic        hit_now;
  logic [HP_W:0] heal_sum;
  pix_t        solid_len, bar_len;

`ifdef HEALTH_BAR_KARMA_EN
  localparam hp_t KR_LAST = hp_t'(KR_DIV - 1);
  hp_t           kr_q, kr_d;
  hp_t           krdiv_q, krdiv_d;
  logic [HP_W:0] kr_sum;
`endif

  // State register; reset restores full HP and drops any pending hit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ALIVE;
      hp_q     <= HP_MAX_V;
      iframe_q <= '0;
      hit_q    <= 1'b0;
      dead_q   <= 1'b0;
      inv_q    <= 1'b0;
`ifdef HEALTH_BAR_KARMA_EN
      kr_q     <= '0;
      krdiv_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      iframe_q <= iframe_d;
      hit_q    <= hit_d;
      dead_q   <= dead_d;
      inv_q    <= inv_d;
`ifdef HEALTH_BAR_KARMA_EN
      kr_q     <= kr_d;
      krdiv_q  <= krdiv_d;
`endif
    end
  end

  // Next-state: frame-boundary damage/iframe/death, then same-cycle heal.
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    iframe_d = iframe_q;
    heal_sum = '0;
    // A trigger on the tick cycle itself belongs to the frame ending now.
    hit_now  = hit_q | bus.is_trigger_player;
    hit_d    = hit_now;
`ifdef HEALTH_BAR_KARMA_EN
    kr_d     = kr_q;
    krdiv_d  = krdiv_q;
    kr_sum   = '0;
`endif

    if (bus.frame_tick) begin
      hit_d = 1'b0;
      case (state_q)
        ALIVE: begin
          if (hit_now) begin
            if (hp_q <= DAMAGE_V) begin
              hp_d    = '0;
              state_d = DEAD;
`ifdef HEALTH_BAR_KARMA_EN
              kr_d    = '0;
`endif
            end else begin
`ifdef HEALTH_BAR_KARMA_EN
              // Damage parks in the karma pool, which never reaches hp.
              kr_sum = {1'b0, kr_q} + {1'b0, DAMAGE_V};
              kr_d   = (kr_sum > {1'b0, hp_q - ONE}) ? hp_q - ONE
                                                      : kr_sum[HP_W-1:0];
`else
              hp_d = hp_q - DAMAGE_V;
`endif
              if (IFRAME_FRAMES > 0) begin
                state_d  = IFRAME;
                iframe_d = IFR_V;
              end
            end
          end
        end
        IFRAME: begin
          iframe_d = iframe_q - ONE;
          if (iframe_q == ONE) state_d = ALIVE;
        end
        default: ;
      endcase

`ifdef HEALTH_BAR_KARMA_EN
      // Karma drains one point of hp every KR_DIV frames while alive.
      if (state_d != DEAD) begin
        if (krdiv_q == KR_LAST) begin
          krdiv_d = '0;
          if (kr_d != '0) begin
            hp_d = hp_d - ONE;
            kr_d = kr_d - ONE;
          end
        end else begin
          krdiv_d = krdiv_q + ONE;
        end
      end
`endif
    end

    // Heal lands after damage; death in the same cycle wins.
    if (bus.heal_valid && state_d != DEAD) begin
      heal_sum = {1'b0, hp_d} + {1'b0, bus.heal_amount};
      hp_d     = (heal_sum > {1'b0, HP_MAX_V}) ? HP_MAX_V : heal_sum[HP_W-1:0];
    end

    dead_d = (state_d == DEAD);
    inv_d  = (state_d == IFRAME);
  end

  assign bus.hp           = hp_q;
  assign bus.dead         = dead_q;
  assign bus.invulnerable = inv_q;

  // Without karma the trailing segment is empty, so karma_bar_signal is 0.
`ifdef HEALTH_BAR_KARMA_EN
  assign solid_len = hp_to_len(hp_q - kr_q, BAR_SCALE);
`else
  assign solid_len = hp_to_len(hp_q, BAR_SCALE);
`endif
  assign bar_len = hp_to_len(hp_q, BAR_SCALE);

  bar_geometry #(
    .BAR_X  (BAR_X),
    .BAR_Y  (BAR_Y),
    .BAR_W  (HP_MAX * BAR_SCALE),
    .BAR_H  (BAR_H),
    .BORDER (BORDER)
  ) u_bar_geometry (
    .x         (bus.x),
    .y         (bus.y),
    .solid_len (solid_len),
    .bar_len   (bar_len),
    .solid     (bus.healt_bar_signal),
    .seg       (bus.karma_bar_signal),
    .border    (bus.healt_bar_border_signal)
  );

endmodule

// File: tb/tb_health_bar_controller.sv
// Directed, self-checking bench for health_bar_controller (default build).
module tb_health_bar_controller;

  logic clk;
  logic reset;

  health_bar_controller_if bus ();

  health_bar_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    int         phase;   // 0: hp=92, 1: hp=90, 2: hp=0
    logic [9:0] x;
    logic [9:0] y;
    logic       fill;
    logic       border;
  } pix_vec_t;

  pix_vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Three quiet cycles then one frame_tick cycle; returns at the negedge
  // after the tick edge, so registered outputs already reflect the frame.
  task automatic frame(input logic trig_on_tick);
    logic saved;
    idle(3);
    saved = bus.is_trigger_player;
    bus.frame_tick = 1'b1;
    if (trig_on_tick) bus.is_trigger_player = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.is_trigger_player = saved;
  endtask

  task automatic heal(input logic [7:0] amt);
    bus.heal_valid  = 1'b1;
    bus.heal_amount = amt;
    @(negedge clk);
    bus.heal_valid  = 1'b0;
    bus.heal_amount = '0;
  endtask

  task automatic check_status(input string tag, input int hp, input int dead,
                              input int inv);
    check({tag, ".hp"}, int'(bus.hp), hp);
    check({tag, ".dead"}, int'(bus.dead), dead);
    check({tag, ".inv"}, int'(bus.invulnerable), inv);
  endtask

  task automatic run_pixels(input int phase);
    foreach (vecs[i]) begin
      if (vecs[i].phase == phase) begin
        bus.x = vecs[i].x;
        bus.y = vecs[i].y;
        #1;
        check({vecs[i].name, ".fill"}, int'(bus.healt_bar_signal), int'(vecs[i].fill));
        check({vecs[i].name, ".border"}, int'(bus.healt_bar_border_signal),
              int'(vecs[i].border));
        check({vecs[i].name, ".karma"}, int'(bus.karma_bar_signal), 0);
      end
    end
    bus.x = '0;
    bus.y = '0;
  endtask

  initial begin
    // Interior x 256..347, y 400..419; border ring x 254..349, y 398..421.
    vecs.push_back('{"p92_last_fill",    0, 10'd347, 10'd400, 1'b1, 1'b0});
    vecs.push_back('{"p92_left_border",  0, 10'd255, 10'd400, 1'b0, 1'b1});
    vecs.push_back('{"p92_first_fill",   0, 10'd256, 10'd400, 1'b1, 1'b0});
    vecs.push_back('{"p92_bottom_fill",  0, 10'd300, 10'd419, 1'b1, 1'b0});
    vecs.push_back('{"p92_right_bord",   0, 10'd348, 10'd419, 1'b0, 1'b1});
    vecs.push_back('{"p92_right_outer",  0, 10'd349, 10'd410, 1'b0, 1'b1});
    vecs.push_back('{"p92_right_out",    0, 10'd350, 10'd410, 1'b0, 1'b0});
    vecs.push_back('{"p92_left_out",     0, 10'd253, 10'd410, 1'b0, 1'b0});
    vecs.push_back('{"p92_top_inner",    0, 10'd300, 10'd399, 1'b0, 1'b1});
    vecs.push_back('{"p92_top_outer",    0, 10'd300, 10'd398, 1'b0, 1'b1});
    vecs.push_back('{"p92_top_out",      0, 10'd300, 10'd397, 1'b0, 1'b0});
    vecs.push_back('{"p92_bot_inner",    0, 10'd300, 10'd420, 1'b0, 1'b1});
    vecs.push_back('{"p92_bot_out",      0, 10'd300, 10'd422, 1'b0, 1'b0});
    vecs.push_back('{"p92_corner_tl",    0, 10'd254, 10'd398, 1'b0, 1'b1});
    vecs.push_back('{"p92_corner_br",    0, 10'd349, 10'd421, 1'b0, 1'b1});
    vecs.push_back('{"p92_origin",       0, 10'd0,   10'd0,   1'b0, 1'b0});
    // hp=90: fill covers x 256..345 only.
    vecs.push_back('{"p90_fill_end",     1, 10'd345, 10'd405, 1'b1, 1'b0});
    vecs.push_back('{"p90_empty",        1, 10'd346, 10'd405, 1'b0, 1'b0});
    vecs.push_back('{"p90_empty_last",   1, 10'd347, 10'd405, 1'b0, 1'b0});
    // hp=0: no fill anywhere, border intact.
    vecs.push_back('{"p0_first",         2, 10'd256, 10'd410, 1'b0, 1'b0});
    vecs.push_back('{"p0_border",        2, 10'd255, 10'd410, 1'b0, 1'b1});

    bus.frame_tick        = 1'b0;
    bus.is_trigger_player = 1'b0;
    bus.heal_valid        = 1'b0;
    bus.heal_amount       = '0;
    bus.x                 = '0;
    bus.y                 = '0;

    // Reset state.
    reset = 1'b1;
    #3;
    check_status("reset", 92, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle frames leave full health.
    repeat (5) frame(1'b0);
    check_status("idle5", 92, 0, 0);
    run_pixels(0);

    // Mid-frame trigger pulse, damage at the tick, then two iframes.
    idle(1);
    bus.is_trigger_player = 1'b1;
    @(negedge clk);
    bus.is_trigger_player = 1'b0;
    frame(1'b0);
    check_status("hit1", 91, 0, 1);
    bus.is_trigger_player = 1'b1;
    frame(1'b0);
    check_status("ifr1", 91, 0, 1);
    frame(1'b0);
    check_status("ifr2", 91, 0, 0);
    frame(1'b0);
    check_status("hit2", 90, 0, 1);
    bus.is_trigger_player = 1'b0;
    frame(1'b0);
    frame(1'b0);
    check_status("recover", 90, 0, 0);
    run_pixels(1);

    // Heal saturates at HP_MAX with 9-bit arithmetic.
    heal(8'd255);
    check_status("heal255", 92, 0, 0);

    // Trigger only on the tick cycle still damages this frame.
    frame(1'b1);
    check_status("tick_trig", 91, 0, 1);
    heal(8'd1);
    check_status("heal_ifr", 92, 0, 1);
    frame(1'b0);
    frame(1'b0);
    check("ifr_done.inv", int'(bus.invulnerable), 0);

    // 42 spaced hits bring hp from 92 to 50.
    for (int k = 0; k < 42; k++) begin
      frame(1'b1);
      frame(1'b0);
      frame(1'b0);
    end
    check_status("hp50", 50, 0, 0);

    // Damage and heal on the same tick: 50-1+5.
    idle(3);
    bus.frame_tick        = 1'b1;
    bus.is_trigger_player = 1'b1;
    bus.heal_valid        = 1'b1;
    bus.heal_amount       = 8'd5;
    @(negedge clk);
    bus.frame_tick        = 1'b0;
    bus.is_trigger_player = 1'b0;
    bus.heal_valid        = 1'b0;
    bus.heal_amount       = '0;
    check_status("dmg_heal", 54, 0, 1);

    // Async reset during IFRAME with a pending hit.
    bus.is_trigger_player = 1'b1;
    @(negedge clk);
    bus.is_trigger_player = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_status("mid_reset", 92, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    frame(1'b0);
    check_status("pend_drop", 92, 0, 0);

    // Trigger held continuously: one hit every third frame until dead.
    bus.is_trigger_player = 1'b1;
    for (int f = 1; f <= 280; f++) begin
      frame(1'b0);
      case (f)
        1:   check_status("hold_f1", 91, 0, 1);
        3:   check_status("hold_f3", 91, 0, 0);
        4:   check_status("hold_f4", 90, 0, 1);
        200: check_status("hold_f200", 25, 0, 1);
        273: check_status("hold_f273", 1, 0, 0);
        274: check_status("hold_f274", 0, 1, 0);
        280: check_status("hold_f280", 0, 1, 0);
        default: ;
      endcase
    end
    bus.is_trigger_player = 1'b0;

    // DEAD ignores heal and stays at zero.
    heal(8'd50);
    check_status("dead_heal", 0, 1, 0);
    frame(1'b0);
    check_status("dead_frame", 0, 1, 0);
    run_pixels(2);

    // Reset is the only way out of DEAD.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_status("revive", 92, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
